phoenix_switch_control: RTL and testbench

- Central routing/allocation controller for one Phoenix router.
- Watches the header-request line `h` of every input buffer and picks one requester per decision, round-robin.
- Computes the XY output port from that requester's header flit and grants it with an `ack_h` pulse when the port is free.
- Holds the input→output connection table driving the crossbar muxes; a connection is released when its input buffer's `sender` falls.

---
 rtl/phoenix_switch_control.sv | 217 +++++++++++++++++++++
 tb/tb_phoenix_switch_control.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phoenix_switch_control.sv
// -----------------------------------------------------------------------------
// phoenix_switch_control
//
// Routing/allocation controller for one Phoenix router. Input buffers raise
// h[i] to ask for a route for the head flit they are presenting on data_in.
// The controller picks one requester per decision in round-robin order,
// computes its XY output port, and grants it with a one-cycle ack_h pulse
// when that output is free. The input->output connection table drives the
// crossbar muxes. A connection is torn down when the owning input's sender
// flag falls.
//
// Decision sequence: IDLE -> ARB (pick) -> ROUTE (XY) -> GRANT -> IDLE.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high reset
//   h        in   [NPORT]           per-input routing request
//   sender   in   [NPORT]           per-input "packet in flight" flag
//   data_in  in   [NPORT*TAM_FLIT]  per-input head flit, port i at [i*TAM_FLIT +: TAM_FLIT]
//   ack_h    out  [NPORT]           one-cycle grant to the selected input
//   free     out  [NPORT]           1 = output port unallocated
//   mux_in   out  [NPORT*3]         per output: index of the input driving it
//   mux_out  out  [NPORT*3]         per input: index of the output it drives
// -----------------------------------------------------------------------------
module phoenix_switch_control #(
    parameter int                  NPORT    = 5,
    parameter int                  TAM_FLIT = 8,
    parameter logic [TAM_FLIT-1:0] ADDRESS  = 8'h00
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NPORT-1:0]          h,
    input  logic [NPORT-1:0]          sender,
    input  logic [NPORT*TAM_FLIT-1:0] data_in,
    output logic [NPORT-1:0]          ack_h,
    output logic [NPORT-1:0]          free,
    output logic [NPORT*3-1:0]        mux_in,
    output logic [NPORT*3-1:0]        mux_out
);

    localparam int SW   = 3;
    localparam int HALF = TAM_FLIT / 2;

    localparam logic [SW-1:0] PORT_EAST  = 3'd0;
    localparam logic [SW-1:0] PORT_WEST  = 3'd1;
    localparam logic [SW-1:0] PORT_NORTH = 3'd2;
    localparam logic [SW-1:0] PORT_SOUTH = 3'd3;
    localparam logic [SW-1:0] PORT_LOCAL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ROUTE = 2'd2,
        S_GRANT = 2'd3
    } state_t;

    // XY routing: resolve X first, then Y; equal coordinates mean local delivery.
    function automatic logic [SW-1:0] xy_route(input logic [TAM_FLIT-1:0] flit);
        logic [HALF-1:0] tx;
        logic [HALF-1:0] ty;
        logic [HALF-1:0] lx;
        logic [HALF-1:0] ly;
        logic [SW-1:0]   res;
        tx = flit[TAM_FLIT-1:HALF];
        ty = flit[HALF-1:0];
        lx = ADDRESS[TAM_FLIT-1:HALF];
        ly = ADDRESS[HALF-1:0];
        if (tx > lx) begin
            res = PORT_EAST;
        end else if (tx < lx) begin
            res = PORT_WEST;
        end else if (ty > ly) begin
            res = PORT_NORTH;
        end else if (ty < ly) begin
            res = PORT_SOUTH;
        end else begin
            res = PORT_LOCAL;
        end
        return res;
    endfunction

    // Round-robin pick: {found, index} of the first requester after last_i.
    // Scanning from the farthest candidate down lets the nearest one win.
    function automatic logic [SW:0] rr_pick(input logic [NPORT-1:0] req,
                                            input logic [SW-1:0]    last_i);
        logic [SW:0] res;
        int          cand;
        res = '0;
        for (int k = NPORT; k >= 1; k--) begin
            cand = int'(last_i) + k;
            if (cand >= NPORT) begin
                cand = cand - NPORT;
            end else begin
                cand = cand;
            end
            if (req[SW'(cand)]) begin
                res = {1'b1, SW'(cand)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t              state_q,  state_d;
    logic [SW-1:0]       sel_q,    sel_d;
    logic [SW-1:0]       last_q,   last_d;
    logic [SW-1:0]       dir_q,    dir_d;
    logic [NPORT-1:0]    free_q,   free_d;
    logic [NPORT-1:0]    sender_q, sender_d;
    logic [SW-1:0]       mux_in_q  [NPORT];
    logic [SW-1:0]       mux_in_d  [NPORT];
    logic [SW-1:0]       mux_out_q [NPORT];
    logic [SW-1:0]       mux_out_d [NPORT];

    logic [TAM_FLIT-1:0] flit_s [NPORT];
    logic [SW:0]         pick_s;
    logic [NPORT-1:0]    ack_h_s;
    logic [NPORT-1:0]    rel_mask_s;

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_ports
            assign flit_s[g]              = data_in[g*TAM_FLIT +: TAM_FLIT];
            assign mux_in[g*SW +: SW]     = mux_in_q[g];
            assign mux_out[g*SW +: SW]    = mux_out_q[g];
        end
    endgenerate

    assign ack_h = ack_h_s;
    assign free  = free_q;

    // Next-state logic for the decision sequence, connection table and releases.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        dir_d      = dir_q;
        free_d     = free_q;
        sender_d   = sender;
        mux_in_d   = mux_in_q;
        mux_out_d  = mux_out_q;
        ack_h_s    = '0;
        rel_mask_s = '0;
        pick_s     = rr_pick(h, last_q);

        case (state_q)
            S_IDLE: begin
                if (|h) begin
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                // A request withdrawn before arbitration simply abandons the decision.
                if (pick_s[SW]) begin
                    sel_d   = pick_s[SW-1:0];
                    state_d = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUTE: begin
                dir_d   = xy_route(flit_s[sel_q]);
                state_d = S_GRANT;
            end
            S_GRANT: begin
                // Uses registered free: a port released this cycle is still busy here.
                if (free_q[dir_q]) begin
                    ack_h_s[sel_q]   = 1'b1;
                    free_d[dir_q]    = 1'b0;
                    mux_in_d[dir_q]  = sel_q;
                    mux_out_d[sel_q] = dir_q;
                end else begin
                    ack_h_s = '0;
                end
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Falling sender frees whatever output that input was driving.
        for (int i = 0; i < NPORT; i++) begin
            rel_mask_s = rel_mask_s |
                         (NPORT'(sender_q[i] & ~sender[i]) << mux_out_q[i]);
        end
        free_d = free_d | rel_mask_s;
    end

    // State and table registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            last_q    <= SW'(NPORT - 1);
            dir_q     <= '0;
            free_q    <= '1;
            sender_q  <= '0;
            mux_in_q  <= '{default: '0};
            mux_out_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            dir_q     <= dir_d;
            free_q    <= free_d;
            sender_q  <= sender_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
        end
    end

endmodule

// File: tb/tb_phoenix_switch_control.sv
module tb_phoenix_switch_control;

    localparam logic [7:0] ADDR = 8'h11;

    logic        clock;
    logic        reset;
    logic [4:0]  h;
    logic [4:0]  sender;
    logic [39:0] data_in;
    logic [4:0]  ack_h;
    logic [4:0]  free;
    logic [14:0] mux_in;
    logic [14:0] mux_out;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model: who owns each output, where each input goes, and
    // how far along the current routing decision is (-1 = none in flight).
    int         m_age;
    int         m_win;
    int         m_wdir;
    int         m_last;
    int         m_owner [5];
    int         m_route [5];
    logic [4:0] m_sprev;
    int         n_grants = 0;

    phoenix_switch_control #(
        .NPORT    (5),
        .TAM_FLIT (8),
        .ADDRESS  (ADDR)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .h       (h),
        .sender  (sender),
        .data_in (data_in),
        .ack_h   (ack_h),
        .free    (free),
        .mux_in  (mux_in),
        .mux_out (mux_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "time limit");
    end

    function automatic int xy(input logic [7:0] f);
        int tx, ty, ax, ay;
        tx = int'(f[7:4]);
        ty = int'(f[3:0]);
        ax = int'(ADDR[7:4]);
        ay = int'(ADDR[3:0]);
        if (tx > ax) return 0;
        if (tx < ax) return 1;
        if (ty > ay) return 2;
        if (ty < ay) return 3;
        return 4;
    endfunction

    task automatic model_step();
        bit found;
        int c;
        if (reset) begin
            m_age  = -1;
            m_win  = 0;
            m_wdir = 0;
            m_last = 4;
            for (int i = 0; i < 5; i++) begin
                m_owner[i] = -1;
                m_route[i] = 0;
            end
            m_sprev = 5'd0;
        end else begin
            if (m_age == 3 && m_owner[m_wdir] < 0) begin
                m_owner[m_wdir] = m_win;
                m_route[m_win]  = m_wdir;
                n_grants++;
            end
            for (int i = 0; i < 5; i++) begin
                if (m_sprev[i] && !sender[i]) m_owner[m_route[i]] = -1;
            end
            if (m_age == -1) begin
                if (h != 5'd0) m_age = 1;
            end else if (m_age == 1) begin
                found = 1'b0;
                for (int k = 1; k <= 5; k++) begin
                    c = (m_last + k) % 5;
                    if (!found && h[c]) begin
                        m_win = c;
                        found = 1'b1;
                    end
                end
                m_age = found ? 2 : -1;
            end else if (m_age == 2) begin
                m_wdir = xy(data_in[m_win*8 +: 8]);
                m_age  = 3;
            end else begin
                m_last = m_win;
                m_age  = -1;
            end
            m_sprev = sender;
        end
    endtask

    // Compare process: every cycle against the model, then advance the model
    // with the inputs the DUT samples at the coming edge.
    initial begin
        logic [4:0] exp_ack;
        logic [4:0] exp_free;
        bit         bad;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                exp_ack = 5'd0;
                if (m_age == 3 && m_owner[m_wdir] < 0) exp_ack[m_win] = 1'b1;
                for (int o = 0; o < 5; o++) exp_free[o] = (m_owner[o] < 0);
                bad = (ack_h !== exp_ack) || (free !== exp_free);
                for (int o = 0; o < 5; o++) begin
                    if (m_owner[o] >= 0 && mux_in[o*3 +: 3] !== 3'(m_owner[o])) bad = 1'b1;
                end
                for (int i = 0; i < 5; i++) begin
                    if (sender[i] && mux_out[i*3 +: 3] !== 3'(m_route[i])) bad = 1'b1;
                end
                tests++;
                if (bad) begin
                    fails++;
                    $display("FAIL model_cycle t=%0t ack=%b want %b free=%b want %b mux_in=%h mux_out=%h",
                             $time, ack_h, exp_ack, free, exp_free, mux_in, mux_out);
                end
            end
            model_step();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input int bound, output logic [4:0] a, output int n);
        a = 5'd0;
        n = 0;
        while (n <= bound) begin
            @(negedge clock);
            if (ack_h != 5'd0) begin
                a = ack_h;
                break;
            end
            n++;
        end
    endtask

    task automatic grant_one(input int p, input logic [7:0] flit, input int free_exp);
        logic [4:0] a;
        int         n;
        tick();
        data_in[p*8 +: 8] = flit;
        h[p] = 1'b1;
        wait_ack(12, a, n);
        chk("grant_latency", n, 3);
        chk("grant_ack", int'(a), 1 << p);
        tick();
        h[p]      = 1'b0;
        sender[p] = 1'b1;
        @(negedge clock);
        chk("grant_free", int'(free), free_exp);
    endtask

    task automatic release_port(input int p, input int free_exp);
        tick();
        sender[p] = 1'b0;
        tick();
        @(negedge clock);
        chk("release_free", int'(free), free_exp);
    endtask

    initial begin
        logic [7:0] hdrs [4];
        int         fexp [4];
        logic [4:0] a;
        int         n;
        int         nacks;
        int         ord [5];
        int         cyc [5];
        int         st  [5];
        int         cnt [5];
        bit         drained;

        hdrs = '{8'h01, 8'h12, 8'h10, 8'h11};
        fexp = '{'h1d, 'h1b, 'h17, 'h0f};

        reset   = 1'b1;
        h       = 5'd0;
        sender  = 5'd0;
        data_in = 40'd0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;
        chk("reset_free", int'(free), 'h1f);
        chk("reset_ack", int'(ack_h), 0);
        chk("reset_mux_in", int'(mux_in), 0);
        chk("reset_mux_out", int'(mux_out), 0);

        // Local port to the east, latency and table entries.
        grant_one(4, 8'h31, 'h1e);
        chk("east_mux_in", int'(mux_in[2:0]), 4);
        chk("local_mux_out", int'(mux_out[14:12]), 0);
        release_port(4, 'h1f);

        // West / North / South / Local from the local port.
        for (int k = 0; k < 4; k++) begin
            grant_one(4, hdrs[k], fexp[k]);
            release_port(4, 'h1f);
        end

        // Two requesters for LOCAL: port 0 wins, port 1 waits for the release.
        tick();
        data_in[7:0]  = 8'h11;
        data_in[15:8] = 8'h11;
        h = 5'b00011;
        wait_ack(12, a, n);
        chk("contend_first_ack", int'(a), 1);
        chk("contend_latency", n, 3);
        tick();
        h[0]      = 1'b0;
        sender[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("blocked_no_ack", int'(ack_h), 0);
        end
        chk("blocked_local_busy", int'(free[4]), 0);
        tick();
        sender[0] = 1'b0;
        wait_ack(12, a, n);
        chk("contend_second_ack", int'(a), 2);
        tick();
        h[1]      = 1'b0;
        sender[1] = 1'b1;
        release_port(1, 'h1f);

        // All five to distinct outputs after a reset: order 0..4, 4 cycles apart.
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        tick();
        data_in = {8'h11, 8'h10, 8'h12, 8'h01, 8'h21};
        h       = 5'b11111;
        nacks   = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            a = ack_h;
            if (a != 5'd0) begin
                if (nacks < 5) begin
                    for (int p = 0; p < 5; p++) if (a[p]) ord[nacks] = p;
                    cyc[nacks] = k;
                end
                nacks++;
            end
            tick();
            if (a != 5'd0) begin
                h      = h & ~a;
                sender = sender | a;
            end
        end
        chk("all5_ack_cycles", nacks, 5);
        for (int k = 0; k < 5; k++) begin
            chk("all5_order", ord[k], k);
            chk("all5_cycle", cyc[k], 3 + 4 * k);
        end
        @(negedge clock);
        chk("all5_free", int'(free), 0);
        tick();
        sender = 5'd0;
        tick();
        @(negedge clock);
        chk("all5_release", int'(free), 'h1f);

        // Release of EAST in the very cycle port 3 is granted EAST.
        grant_one(2, 8'h21, 'h1e);
        tick();
        data_in[31:24] = 8'h21;
        h[3] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                tick();
                if (k == 3) sender[2] = 1'b0;
                if (k == 8) begin
                    h[3]      = 1'b0;
                    sender[3] = 1'b1;
                end
            end
            @(negedge clock);
            chk("race_free_east", int'(free[0]), (k >= 4 && k <= 7) ? 1 : 0);
            chk("race_ack", int'(ack_h), (k == 7) ? 8 : 0);
        end
        release_port(3, 'h1f);

        // Reset during ROUTE restarts arbitration from port 0.
        tick();
        data_in[7:0]   = 8'h21;
        data_in[39:32] = 8'h01;
        h = 5'b10001;
        @(negedge clock);
        tick();
        @(negedge clock);
        tick();
        reset = 1'b1;
        @(negedge clock);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_route_ack", int'(ack_h), 0);
        chk("rst_route_free", int'(free), 'h1f);
        wait_ack(12, a, n);
        chk("rst_first_port0", int'(a), 1);
        tick();
        h[0]      = 1'b0;
        sender[0] = 1'b1;
        wait_ack(12, a, n);
        chk("rst_then_port4", int'(a), 16);
        tick();
        h[4]      = 1'b0;
        sender[4] = 1'b1;
        tick();
        sender = 5'd0;
        tick();
        @(negedge clock);
        chk("rst_release", int'(free), 'h1f);

        // Randomised traffic: buffers request, hold the connection, release.
        n_grants = 0;
        for (int p = 0; p < 5; p++) begin
            st[p]  = 0;
            cnt[p] = 0;
        end
        for (int c = 0; c < 3200; c++) begin
            @(negedge clock);
            a = ack_h;
            tick();
            for (int p = 0; p < 5; p++) begin
                if (st[p] == 0) begin
                    data_in[p*8 +: 8] = 8'($urandom);
                    if (c < 3000 && $urandom_range(0, 7) == 0) begin
                        data_in[p*8 +: 8] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
                        h[p]  = 1'b1;
                        st[p] = 1;
                    end
                end else if (st[p] == 1) begin
                    if (a[p]) begin
                        h[p]      = 1'b0;
                        sender[p] = 1'b1;
                        cnt[p]    = int'($urandom_range(1, 10));
                        st[p]     = 2;
                    end
                end else begin
                    data_in[p*8 +: 8] = 8'($urandom);
                    if (cnt[p] == 0) begin
                        sender[p] = 1'b0;
                        st[p]     = 0;
                    end else begin
                        cnt[p]--;
                    end
                end
            end
        end
        drained = 1'b1;
        for (int p = 0; p < 5; p++) if (st[p] != 0) drained = 1'b0;
        chk("random_drained", int'(drained), 1);
        chk("random_enough_grants", (n_grants >= 100) ? 1 : 0, 1);
        tick();
        @(negedge clock);
        chk("random_final_free", int'(free), 'h1f);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
